// File: rtl/cv32e40p_apu_tracker.sv
// In-order tracker for operations in flight on a shared APU, with writeback and RAW hazard flags.
// Optional issue-to-result latency monitor is enabled by defining CV32E40P_APU_LAT_MON_EN.
module cv32e40p_apu_tracker #(
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NDSFLAGS_CPU = 15,
  parameter int unsigned APU_NUSFLAGS_CPU = 5,
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned REGADDR_W        = 6,
  parameter int unsigned NRPORTS          = 3
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [APU_NARGS_CPU*32-1:0]     req_operands_i,
  input  logic [APU_WOP_CPU-1:0]          req_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]     req_flags_i,
  input  logic [REGADDR_W-1:0]            req_waddr_i,

  output logic                            apu_req_o,
  input  logic                            apu_gnt_i,
  output logic [APU_NARGS_CPU*32-1:0]     apu_operands_o,
  output logic [APU_WOP_CPU-1:0]          apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]     apu_flags_o,
  input  logic                            apu_rvalid_i,
  input  logic [31:0]                     apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]     apu_flags_i,

  output logic                            wb_valid_o,
  output logic [REGADDR_W-1:0]            wb_waddr_o,
  output logic [31:0]                     wb_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]     wb_flags_o,

  input  logic [NRPORTS*REGADDR_W-1:0]    rd_addr_i,
  output logic [NRPORTS-1:0]              rd_hazard_o,

  output logic [$clog2(DEPTH+1)-1:0]      outstanding_o,
  output logic                            full_o,
  output logic                            busy_o,
  output logic                            err_rvalid_o,
  output logic [15:0]                     max_lat_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]            count_q;
  logic [PTR_W-1:0]            wptr_q;
  logic [PTR_W-1:0]            rptr_q;
  logic [REGADDR_W-1:0]        tag_q [DEPTH];
  logic [DEPTH-1:0]            vld_q;

  logic                        wb_valid_q;
  logic [REGADDR_W-1:0]        wb_waddr_q;
  logic [31:0]                 wb_result_q;
  logic [APU_NUSFLAGS_CPU-1:0] wb_flags_q;
  logic                        err_q;

  logic full;
  logic push;
  logic pop;

  // Full looks only at registered occupancy, so a pop never frees a slot in the same cycle.
  assign full = (count_q == CNT_W'(DEPTH));
  assign push = req_valid_i & ~full & apu_gnt_i;
  assign pop  = apu_rvalid_i & (count_q != '0);

  assign apu_req_o      = req_valid_i & ~full;
  assign req_ready_o    = push;
  assign apu_operands_o = req_operands_i;
  assign apu_op_o       = req_op_i;
  assign apu_flags_o    = req_flags_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      vld_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_waddr_q  <= '0;
      wb_result_q <= '0;
      wb_flags_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wptr_q] <= req_waddr_i;
        vld_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      // Push and pop never target the same slot: a pop needs an entry, a push needs a free slot.
      if (pop) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + PTR_W'(1);
        wb_waddr_q    <= tag_q[rptr_q];
        wb_result_q   <= apu_result_i;
        wb_flags_q    <= apu_flags_i;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      wb_valid_q <= pop;
      if (apu_rvalid_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_waddr_o    = wb_waddr_q;
  assign wb_result_o   = wb_result_q;
  assign wb_flags_o    = wb_flags_q;
  assign outstanding_o = count_q;
  assign full_o        = full;
  assign busy_o        = (count_q != '0) | wb_valid_q;
  assign err_rvalid_o  = err_q;

  // Register x0 is hard-wired, so it is never reported as a hazard.
  for (genvar p = 0; p < NRPORTS; p++) begin : g_haz
    logic [REGADDR_W-1:0] rdAddr;
    logic [DEPTH-1:0]     entHit;
    assign rdAddr = rd_addr_i[p*REGADDR_W +: REGADDR_W];
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      assign entHit[e] = vld_q[e] & (tag_q[e] == rdAddr);
    end
    assign rd_hazard_o[p] = (rdAddr != '0) &
                            ((|entHit) | (wb_valid_q & (wb_waddr_q == rdAddr)));
  end

`ifdef CV32E40P_APU_LAT_MON_EN
  logic [15:0] cycle_q;
  logic [15:0] stamp_q [DEPTH];
  logic [15:0] max_lat_q;
  logic [15:0] popLat;

  // Modular subtraction keeps the latency correct across counter wrap.
  assign popLat = cycle_q - stamp_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      max_lat_q <= '0;
    end else begin
      cycle_q <= cycle_q + 16'd1;
      if (push) begin
        stamp_q[wptr_q] <= cycle_q;
      end
      if (pop && (popLat > max_lat_q)) begin
        max_lat_q <= popLat;
      end
    end
  end

  assign max_lat_o = max_lat_q;
`else
  assign max_lat_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_tracker.sv
// Scoreboard bench for cv32e40p_apu_tracker: a reference FIFO predicts writebacks, checked when wb_valid_o fires.
module tb_cv32e40p_apu_tracker;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [95:0] req_operands_i;
  logic [5:0]  req_op_i;
  logic [14:0] req_flags_i;
  logic [5:0]  req_waddr_i;
  logic        apu_req_o;
  logic        apu_gnt_i;
  logic [95:0] apu_operands_o;
  logic [5:0]  apu_op_o;
  logic [14:0] apu_flags_o;
  logic        apu_rvalid_i;
  logic [31:0] apu_result_i;
  logic [4:0]  apu_flags_i;
  logic        wb_valid_o;
  logic [5:0]  wb_waddr_o;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_flags_o;
  logic [17:0] rd_addr_i;
  logic [2:0]  rd_hazard_o;
  logic [2:0]  outstanding_o;
  logic        full_o;
  logic        busy_o;
  logic        err_rvalid_o;
  logic [15:0] max_lat_o;

  cv32e40p_apu_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_operands_i (req_operands_i),
    .req_op_i       (req_op_i),
    .req_flags_i    (req_flags_i),
    .req_waddr_i    (req_waddr_i),
    .apu_req_o      (apu_req_o),
    .apu_gnt_i      (apu_gnt_i),
    .apu_operands_o (apu_operands_o),
    .apu_op_o       (apu_op_o),
    .apu_flags_o    (apu_flags_o),
    .apu_rvalid_i   (apu_rvalid_i),
    .apu_result_i   (apu_result_i),
    .apu_flags_i    (apu_flags_i),
    .wb_valid_o     (wb_valid_o),
    .wb_waddr_o     (wb_waddr_o),
    .wb_result_o    (wb_result_o),
    .wb_flags_o     (wb_flags_o),
    .rd_addr_i      (rd_addr_i),
    .rd_hazard_o    (rd_hazard_o),
    .outstanding_o  (outstanding_o),
    .full_o         (full_o),
    .busy_o         (busy_o),
    .err_rvalid_o   (err_rvalid_o),
    .max_lat_o      (max_lat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  waddr;
    logic [31:0] result;
    logic [4:0]  flags;
  } wb_exp_t;

  wb_exp_t    sbq [$];
  logic [5:0] mf [$];
  logic       expErr;
  int         total;
  int         bad;

  // Drives one cycle of stimulus, updates the reference model, and steps past the clock edge.
  task automatic drive(input logic v, input logic [5:0] wa, input logic g,
                       input logic rv, input logic [31:0] res, input logic [4:0] fl,
                       input logic r);
    int sz;
    wb_exp_t e;
    req_valid_i    = v;
    req_waddr_i    = wa;
    apu_gnt_i      = g;
    apu_rvalid_i   = rv;
    apu_result_i   = res;
    apu_flags_i    = fl;
    rst            = r;
    req_operands_i = {$urandom, $urandom, $urandom};
    req_op_i       = 6'($urandom);
    req_flags_i    = 15'($urandom);
    if (r) begin
      mf.delete();
      sbq.delete();
      expErr = 1'b0;
    end else begin
      sz = mf.size();
      if (rv) begin
        if (sz > 0) begin
          e.waddr  = mf.pop_front();
          e.result = res;
          e.flags  = fl;
          sbq.push_back(e);
        end else begin
          expErr = 1'b1;
        end
      end
      if (v && g && (sz < DEPTH)) mf.push_back(wa);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
  endtask

  // Writeback scoreboard: every strobe must match the oldest predicted result.
  always @(negedge clk) begin
    if (wb_valid_o === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL wb_unexpected: got waddr=%0d result=%h, expected no writeback", wb_waddr_o, wb_result_o);
      end else begin
        wb_exp_t e;
        e = sbq.pop_front();
        if (wb_waddr_o !== e.waddr || wb_result_o !== e.result || wb_flags_o !== e.flags) begin
          bad++;
          $display("[TB] FAIL wb_data: got waddr=%0d result=%h flags=%h, expected waddr=%0d result=%h flags=%h",
                   wb_waddr_o, wb_result_o, wb_flags_o, e.waddr, e.result, e.flags);
        end
      end
    end
  end

  task automatic test_reset();
    rd_addr_i = '0;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1);
    total++;
    if ({outstanding_o, full_o, busy_o, wb_valid_o, err_rvalid_o, apu_req_o, req_ready_o, rd_hazard_o} !== 12'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got occ=%0d full=%b busy=%b wbv=%b err=%b req=%b rdy=%b haz=%b, expected all 0",
               outstanding_o, full_o, busy_o, wb_valid_o, err_rvalid_o, apu_req_o, req_ready_o, rd_hazard_o);
    end
    total++;
    if (max_lat_o !== 16'd0 || wb_waddr_o !== 6'd0 || wb_result_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_regs: got maxlat=%0d waddr=%0d result=%h, expected 0", max_lat_o, wb_waddr_o, wb_result_o);
    end
    idle();
  endtask

  task automatic test_single();
    req_valid_i = 1'b1;
    apu_gnt_i   = 1'b0;
    req_op_i    = 6'h2a;
    #1;
    total++;
    if (apu_req_o !== 1'b1 || req_ready_o !== 1'b0 || apu_op_o !== 6'h2a) begin
      bad++;
      $display("[TB] FAIL req_no_gnt: got req=%b rdy=%b op=%h, expected req=1 rdy=0 op=2a", apu_req_o, req_ready_o, apu_op_o);
    end
    apu_gnt_i = 1'b1;
    #1;
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL req_gnt: got rdy=%b, expected 1", req_ready_o);
    end
    drive(1'b1, 6'd5, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
    total++;
    if (outstanding_o !== 3'd1) begin
      bad++;
      $display("[TB] FAIL single_occ1: got %0d, expected 1", outstanding_o);
    end
    idle();
    idle();
    drive(1'b0, 6'd0, 1'b0, 1'b1, 32'hDEADBEEF, 5'h13, 1'b0);
    total++;
    if (outstanding_o !== 3'd0 || wb_valid_o !== 1'b1 || wb_waddr_o !== 6'd5 || wb_result_o !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL single_wb: got occ=%0d wbv=%b waddr=%0d result=%h, expected occ=0 wbv=1 waddr=5 result=deadbeef",
               outstanding_o, wb_valid_o, wb_waddr_o, wb_result_o);
    end
    total++;
`ifdef CV32E40P_APU_LAT_MON_EN
    if (max_lat_o !== 16'd3) begin
      bad++;
      $display("[TB] FAIL single_maxlat: got %0d, expected 3", max_lat_o);
    end
`else
    if (max_lat_o !== 16'd0) begin
      bad++;
      $display("[TB] FAIL single_maxlat: got %0d, expected 0", max_lat_o);
    end
`endif
    idle();
    total++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_after: got wbv=%b busy=%b, expected 0 0", wb_valid_o, busy_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) drive(1'b1, 6'(i), 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
    total++;
    if (full_o !== 1'b1 || outstanding_o !== 3'd4 || busy_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fill_full: got full=%b occ=%0d busy=%b, expected 1 4 1", full_o, outstanding_o, busy_o);
    end
    req_valid_i = 1'b1;
    apu_gnt_i   = 1'b1;
    #1;
    total++;
    if (apu_req_o !== 1'b0 || req_ready_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fill_block: got req=%b rdy=%b, expected 0 0", apu_req_o, req_ready_o);
    end
    drive(1'b1, 6'd9, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
    total++;
    if (outstanding_o !== 3'd4) begin
      bad++;
      $display("[TB] FAIL fill_hold: got %0d, expected 4", outstanding_o);
    end
    for (int i = 1; i <= 4; i++) drive(1'b0, 6'd0, 1'b0, 1'b1, 32'h100 + 32'(i), 5'(i), 1'b0);
    idle();
    total++;
    if (outstanding_o !== 3'd0 || full_o !== 1'b0 || sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL fill_drain: got occ=%0d full=%b pending=%0d, expected 0 0 0", outstanding_o, full_o, sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 6'd10, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
    drive(1'b1, 6'd11, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(12 + i), 1'b1, 1'b1, 32'hA000 + 32'(i), 5'(i + 7), 1'b0);
      total++;
      if (outstanding_o !== 3'd2 || wb_valid_o !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_occ: got occ=%0d wbv=%b, expected 2 1", outstanding_o, wb_valid_o);
      end
    end
    drive(1'b0, 6'd0, 1'b0, 1'b1, 32'hB000, 5'd1, 1'b0);
    drive(1'b0, 6'd0, 1'b0, 1'b1, 32'hB001, 5'd2, 1'b0);
    idle();
    total++;
    if (outstanding_o !== 3'd0 || sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL b2b_drain: got occ=%0d pending=%0d, expected 0 0", outstanding_o, sbq.size());
    end
  endtask

  task automatic test_hazard();
    req_valid_i = 1'b1;
    apu_gnt_i   = 1'b1;
    req_waddr_i = 6'd7;
    rd_addr_i   = {6'd0, 6'd0, 6'd7};
    #1;
    total++;
    if (rd_hazard_o !== 3'b000) begin
      bad++;
      $display("[TB] FAIL haz_same_cycle: got %b, expected 000", rd_hazard_o);
    end
    drive(1'b1, 6'd7, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
    rd_addr_i = {6'd3, 6'd0, 6'd7};
    #1;
    total++;
    if (rd_hazard_o !== 3'b001) begin
      bad++;
      $display("[TB] FAIL haz_basic: got %b, expected 001", rd_hazard_o);
    end
    drive(1'b1, 6'd0, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
    rd_addr_i = '0;
    #1;
    total++;
    if (rd_hazard_o !== 3'b000) begin
      bad++;
      $display("[TB] FAIL haz_x0: got %b, expected 000", rd_hazard_o);
    end
    rd_addr_i = {6'd0, 6'd7, 6'd8};
    #1;
    total++;
    if (rd_hazard_o !== 3'b010) begin
      bad++;
      $display("[TB] FAIL haz_port1: got %b, expected 010", rd_hazard_o);
    end
    drive(1'b0, 6'd0, 1'b0, 1'b1, 32'h77, 5'd0, 1'b0);
    rd_addr_i = {6'd0, 6'd0, 6'd7};
    #1;
    total++;
    if (rd_hazard_o !== 3'b001) begin
      bad++;
      $display("[TB] FAIL haz_wb: got %b, expected 001", rd_hazard_o);
    end
    drive(1'b0, 6'd0, 1'b0, 1'b1, 32'h78, 5'd0, 1'b0);
    idle();
    total++;
    if (rd_hazard_o !== 3'b000) begin
      bad++;
      $display("[TB] FAIL haz_clear: got %b, expected 000", rd_hazard_o);
    end
  endtask

  task automatic test_spurious();
    drive(1'b1, 6'd20, 1'b1, 1'b1, 32'hBAD0BAD0, 5'd31, 1'b0);
    total++;
    if (err_rvalid_o !== expErr || err_rvalid_o !== 1'b1 || wb_valid_o !== 1'b0 || outstanding_o !== 3'd1) begin
      bad++;
      $display("[TB] FAIL spur_err: got err=%b wbv=%b occ=%0d, expected 1 0 1", err_rvalid_o, wb_valid_o, outstanding_o);
    end
    idle();
    idle();
    total++;
    if (err_rvalid_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL spur_sticky: got %b, expected 1", err_rvalid_o);
    end
    drive(1'b0, 6'd0, 1'b0, 1'b1, 32'h2020, 5'd4, 1'b0);
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) drive(1'b1, 6'(i), 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
    total++;
    if (outstanding_o !== 3'd3) begin
      bad++;
      $display("[TB] FAIL rstmid_occ: got %0d, expected 3", outstanding_o);
    end
    rd_addr_i = {6'd1, 6'd2, 6'd3};
    drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1);
    total++;
    if (outstanding_o !== 3'd0 || busy_o !== 1'b0 || rd_hazard_o !== 3'b000 || wb_valid_o !== 1'b0 || err_rvalid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_clear: got occ=%0d busy=%b haz=%b wbv=%b err=%b, expected all 0",
               outstanding_o, busy_o, rd_hazard_o, wb_valid_o, err_rvalid_o);
    end
    idle();
    drive(1'b0, 6'd0, 1'b0, 1'b1, 32'h5A5A, 5'd3, 1'b0);
    total++;
    if (err_rvalid_o !== expErr || err_rvalid_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_late: got err=%b wbv=%b, expected 1 0", err_rvalid_o, wb_valid_o);
    end
    idle();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    expErr         = 1'b0;
    rst            = 1'b1;
    req_valid_i    = 1'b0;
    req_operands_i = '0;
    req_op_i       = '0;
    req_flags_i    = '0;
    req_waddr_i    = '0;
    apu_gnt_i      = 1'b0;
    apu_rvalid_i   = 1'b0;
    apu_result_i   = '0;
    apu_flags_i    = '0;
    rd_addr_i      = '0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_hazard();
    test_spurious();
    test_reset_mid();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL wb_missing: got %0d writebacks never seen, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
